// File: rtl/uart_rx_deser_gen.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_gen
//
// Receive-side deserializer for the UART RX path. Collects one sampled bit per
// deser_en strobe into a frame of runtime-selectable length (1..DATA_WIDTH),
// LSB-first or MSB-first. It also keeps a running parity over the frame. A
// completed frame moves into a holding register that the consumer drains with
// a valid/ready handshake. A frame that completes while the holding register
// is still occupied is dropped and flagged with a one-cycle overrun pulse.
//
// Ports
//   clk         : clock, all logic on the rising edge
//   rst         : asynchronous active-high reset
//   deser_en    : one-cycle strobe, sampled_bit is consumed this cycle
//   sampled_bit : received data bit
//   data_len    : frame length in bits (0 or >DATA_WIDTH means DATA_WIDTH),
//                 captured at frame start
//   msb_first   : 0 = first bit is LSB, 1 = first bit is MSB (captured at start)
//   par_odd     : 0 = even parity, 1 = odd parity (captured at start)
//   clear       : synchronous abort of the frame in progress
//   p_data      : held frame data, right-aligned, upper bits zero
//   p_parity    : expected parity bit for the held frame
//   p_valid     : holding register contains an unconsumed frame
//   p_ready     : consumer accepts the frame when p_valid && p_ready
//   busy        : a frame is partially received
//   overrun     : one-cycle pulse when a completed frame is dropped
// -----------------------------------------------------------------------------
module uart_rx_deser_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  deser_en,
  input  logic                  sampled_bit,
  input  logic [LEN_W-1:0]      data_len,
  input  logic                  msb_first,
  input  logic                  par_odd,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  p_parity,
  output logic                  p_valid,
  input  logic                  p_ready,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_WIDTH);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  // Out-of-range requested lengths fall back to the full data width.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] req);
    if (req == '0 || req > MAX_LEN) begin
      return MAX_LEN;
    end
    return req;
  endfunction

  // Frame assembly state
  logic [LEN_W-1:0]      cnt_q,   cnt_d;
  logic [LEN_W-1:0]      len_q,   len_d;
  logic                  msb_q,   msb_d;
  logic                  odd_q,   odd_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q,   par_d;

  // Holding register and status
  logic [DATA_WIDTH-1:0] pdata_q,   pdata_d;
  logic                  ppar_q,    ppar_d;
  logic                  pvalid_q,  pvalid_d;
  logic                  overrun_q, overrun_d;
  logic                  busy_q,    busy_d;

  // Working signals for the current strobe
  logic                  start;
  logic [LEN_W-1:0]      cur_len;
  logic                  cur_msb;
  logic                  cur_odd;
  logic [DATA_WIDTH-1:0] shreg_base;
  logic                  par_base;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic                  par_nxt;
  logic                  last;
  logic                  hold_free;

  always_comb begin
    start = deser_en && (cnt_q == '0);

    // On the first bit the frame settings come straight from the inputs so the
    // first bit already uses the new length/order; afterwards the captured copy.
    cur_len = start ? eff_len(data_len) : len_q;
    cur_msb = start ? msb_first         : msb_q;
    cur_odd = start ? par_odd           : odd_q;

    // Frame start discards any leftover assembly state.
    shreg_base = start ? '0   : shreg_q;
    par_base   = start ? 1'b0 : par_q;

    // MSB-first shifts left so the first bit ends up at position len-1 once
    // len bits are in; LSB-first drops bit k straight into position k.
    if (cur_msb) begin
      shreg_nxt = {shreg_base[DATA_WIDTH-2:0], sampled_bit};
    end else begin
      shreg_nxt = shreg_base | (DATA_WIDTH'(sampled_bit) << cnt_q);
    end
    par_nxt = par_base ^ sampled_bit;

    last      = deser_en && (cnt_q == (cur_len - ONE));
    hold_free = !pvalid_q || p_ready;

    cnt_d     = cnt_q;
    len_d     = len_q;
    msb_d     = msb_q;
    odd_d     = odd_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    pdata_d   = pdata_q;
    ppar_d    = ppar_q;
    pvalid_d  = pvalid_q;
    overrun_d = 1'b0;

    // Consumer handshake; a completion below may set it again this cycle.
    if (pvalid_q && p_ready) begin
      pvalid_d = 1'b0;
    end

    if (clear) begin
      // Abort wins over a coincident strobe; the holding register is untouched.
      cnt_d   = '0;
      shreg_d = '0;
      par_d   = 1'b0;
    end else if (deser_en) begin
      if (start) begin
        len_d = cur_len;
        msb_d = cur_msb;
        odd_d = cur_odd;
      end
      if (last) begin
        cnt_d   = '0;
        shreg_d = '0;
        par_d   = 1'b0;
        if (hold_free) begin
          pdata_d  = shreg_nxt;
          ppar_d   = par_nxt ^ cur_odd;
          pvalid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        cnt_d   = cnt_q + ONE;
        shreg_d = shreg_nxt;
        par_d   = par_nxt;
      end
    end

    busy_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      len_q     <= MAX_LEN;
      msb_q     <= 1'b0;
      odd_q     <= 1'b0;
      shreg_q   <= '0;
      par_q     <= 1'b0;
      pdata_q   <= '0;
      ppar_q    <= 1'b0;
      pvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      msb_q     <= msb_d;
      odd_q     <= odd_d;
      shreg_q   <= shreg_d;
      par_q     <= par_d;
      pdata_q   <= pdata_d;
      ppar_q    <= ppar_d;
      pvalid_q  <= pvalid_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_d;
    end
  end

  assign p_data   = pdata_q;
  assign p_parity = ppar_q;
  assign p_valid  = pvalid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_deser_gen.sv
module tb_uart_rx_deser_gen;

  localparam int DW = 8;
  localparam int LW = $clog2(DW + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          deser_en;
  logic          sampled_bit;
  logic [LW-1:0] data_len;
  logic          msb_first;
  logic          par_odd;
  logic          clear;
  logic [DW-1:0] p_data;
  logic          p_parity;
  logic          p_valid;
  logic          p_ready;
  logic          busy;
  logic          overrun;

  int errors = 0;
  int checks = 0;

  uart_rx_deser_gen #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .deser_en   (deser_en),
    .sampled_bit(sampled_bit),
    .data_len   (data_len),
    .msb_first  (msb_first),
    .par_odd    (par_odd),
    .clear      (clear),
    .p_data     (p_data),
    .p_parity   (p_parity),
    .p_valid    (p_valid),
    .p_ready    (p_ready),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // seq[i] is the i-th bit put on the line; nbits is the effective length.
  typedef struct {
    logic [LW-1:0] len_in;
    logic          msb;
    logic          odd;
    logic [7:0]    seq;
    int            nbits;
    logic [7:0]    exp_data;
    logic          exp_par;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    deser_en    = 1'b1;
    sampled_bit = b;
    tick();
    deser_en    = 1'b0;
  endtask

  // Sends n bits back to back; counts busy cycles and, when asked, confirms
  // the frame does not complete one bit early.
  task automatic send_seq(input logic [7:0] seq, input int n, input bit perturb,
                          input bit chk_early, input string tag, output int bcnt);
    bcnt = 0;
    for (int i = 0; i < n; i++) begin
      send_bit(seq[i]);
      if (busy) bcnt++;
      if (perturb && i == 0) begin
        data_len  = LW'(2);
        msb_first = !msb_first;
        par_odd   = !par_odd;
      end
      if (chk_early && n > 1 && i == n - 2) begin
        check({tag, "_early_valid"}, 32'(p_valid), 32'd0);
      end
    end
  endtask

  task automatic set_cfg(input logic [LW-1:0] l, input logic m, input logic o);
    data_len  = l;
    msb_first = m;
    par_odd   = o;
  endtask

  initial begin
    int bc;
    string t;

    vecs[0] = '{LW'(8),  1'b0, 1'b0, 8'h4D, 8, 8'h4D, 1'b0};
    vecs[1] = '{LW'(5),  1'b1, 1'b1, 8'h1D, 5, 8'h17, 1'b1};
    vecs[2] = '{LW'(0),  1'b0, 1'b0, 8'hA5, 8, 8'hA5, 1'b0};
    vecs[3] = '{LW'(15), 1'b1, 1'b0, 8'h3C, 8, 8'h3C, 1'b0};
    vecs[4] = '{LW'(1),  1'b0, 1'b1, 8'h01, 1, 8'h01, 1'b0};
    vecs[5] = '{LW'(3),  1'b0, 1'b1, 8'h06, 3, 8'h06, 1'b1};
    vecs[6] = '{LW'(7),  1'b1, 1'b0, 8'h53, 7, 8'h65, 1'b0};
    vecs[7] = '{LW'(8),  1'b1, 1'b1, 8'h01, 8, 8'h80, 1'b0};

    rst = 1'b1; deser_en = 1'b0; sampled_bit = 1'b0; clear = 1'b0; p_ready = 1'b0;
    set_cfg(LW'(8), 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("reset_p_data",   32'(p_data),   32'd0);
    check("reset_p_parity", 32'(p_parity), 32'd0);
    check("reset_p_valid",  32'(p_valid),  32'd0);
    check("reset_overrun",  32'(overrun),  32'd0);
    check("reset_busy",     32'(busy),     32'd0);

    // Table-driven frames; settings are perturbed after the first bit.
    for (int v = 0; v < 8; v++) begin
      t = $sformatf("vec%0d", v);
      set_cfg(vecs[v].len_in, vecs[v].msb, vecs[v].odd);
      p_ready = 1'b0;
      send_seq(vecs[v].seq, vecs[v].nbits, 1'b1, 1'b1, t, bc);
      check({t, "_valid"},   32'(p_valid),  32'd1);
      check({t, "_data"},    32'(p_data),   32'(vecs[v].exp_data));
      check({t, "_parity"},  32'(p_parity), 32'(vecs[v].exp_par));
      check({t, "_overrun"}, 32'(overrun),  32'd0);
      check({t, "_busy_cycles"}, 32'(bc),   32'(vecs[v].nbits - 1));
      check({t, "_busy_end"},    32'(busy), 32'd0);
      p_ready = 1'b1;
      tick();
      p_ready = 1'b0;
      check({t, "_consumed"}, 32'(p_valid), 32'd0);
    end

    // Overrun: second frame completes while the first is unread.
    set_cfg(LW'(8), 1'b0, 1'b0);
    send_seq(8'hA5, 8, 1'b0, 1'b1, "ovr1", bc);
    check("ovr_first_data", 32'(p_data), 32'hA5);
    send_seq(8'h3C, 8, 1'b0, 1'b0, "ovr2", bc);
    check("ovr_pulse",      32'(overrun), 32'd1);
    check("ovr_keep_data",  32'(p_data),  32'hA5);
    check("ovr_keep_valid", 32'(p_valid), 32'd1);
    tick();
    check("ovr_pulse_end",  32'(overrun), 32'd0);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("ovr_drain", 32'(p_valid), 32'd0);

    // Ready in the same cycle a new frame completes: seamless reload.
    send_seq(8'hA5, 8, 1'b0, 1'b0, "sim1", bc);
    send_seq(8'h3C, 7, 1'b0, 1'b0, "sim2", bc);
    p_ready = 1'b1;
    send_bit(1'b0);
    p_ready = 1'b0;
    check("simul_valid",   32'(p_valid), 32'd1);
    check("simul_data",    32'(p_data),  32'h3C);
    check("simul_overrun", 32'(overrun), 32'd0);
    p_ready = 1'b1;
    tick();
    p_ready = 1'b0;
    check("simul_drain", 32'(p_valid), 32'd0);

    // Clear after three bits, then full frames.
    send_seq(8'h07, 3, 1'b0, 1'b0, "clr_a", bc);
    check("clr_busy_before", 32'(busy), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_busy_after",  32'(busy),    32'd0);
    check("clr_valid_after", 32'(p_valid), 32'd0);
    send_seq(8'hFF, 8, 1'b0, 1'b1, "clr_ff", bc);
    check("clr_ff_data",   32'(p_data),   32'hFF);
    check("clr_ff_parity", 32'(p_parity), 32'd0);
    p_ready = 1'b1; tick(); p_ready = 1'b0;

    // Odd parity after an aborted odd-weight prefix: leftover parity would flip it.
    set_cfg(LW'(8), 1'b0, 1'b1);
    send_seq(8'h01, 1, 1'b0, 1'b0, "clr_p", bc);
    clear = 1'b1; tick(); clear = 1'b0;
    send_seq(8'h00, 8, 1'b0, 1'b1, "clr_00", bc);
    check("clr_00_data",   32'(p_data),   32'h00);
    check("clr_00_parity", 32'(p_parity), 32'd1);
    p_ready = 1'b1; tick(); p_ready = 1'b0;

    // Clear coincident with a strobe: that bit is discarded.
    set_cfg(LW'(8), 1'b0, 1'b0);
    send_seq(8'h01, 2, 1'b0, 1'b0, "clr_b", bc);
    deser_en = 1'b1; sampled_bit = 1'b1; clear = 1'b1;
    tick();
    deser_en = 1'b0; clear = 1'b0;
    check("clr_coinc_busy", 32'(busy), 32'd0);
    send_seq(8'h5A, 8, 1'b0, 1'b1, "clr_coinc", bc);
    check("clr_coinc_valid", 32'(p_valid), 32'd1);
    check("clr_coinc_data",  32'(p_data),  32'h5A);
    // Holding register stays full across the next abort.
    send_seq(8'h03, 2, 1'b0, 1'b0, "clr_keep", bc);
    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_keep_valid", 32'(p_valid), 32'd1);
    check("clr_keep_data",  32'(p_data),  32'h5A);

    // Asynchronous reset mid-frame with a frame still held.
    send_seq(8'h0F, 4, 1'b0, 1'b0, "rst_mid", bc);
    rst = 1'b1;
    #2;
    check("rst_p_data",  32'(p_data),  32'd0);
    check("rst_p_valid", 32'(p_valid), 32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    tick();
    rst = 1'b0;
    send_seq(8'hC3, 8, 1'b0, 1'b1, "rst_next", bc);
    check("rst_next_valid",   32'(p_valid),  32'd1);
    check("rst_next_data",    32'(p_data),   32'hC3);
    check("rst_next_parity",  32'(p_parity), 32'd0);
    check("rst_next_overrun", 32'(overrun),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deser_gen.md
# uart_rx_deser_gen

Parametrised receive-side deserializer for the UART RX path. It collects one sampled bit per `deser_en` strobe into a frame of runtime-selectable length (1..DATA_WIDTH), in LSB-first or MSB-first order, and computes the frame parity. Each completed frame moves into an output holding register with a valid/ready handshake and overrun detection. It sits between the RX FSM/sampler and the RX data consumer (parity check, sync stage, register file).

## Interface
- `DATA_WIDTH`, 8, maximum frame data bits; must be ≥ 2.
- `LEN_W`, `$clog2(DATA_WIDTH+1)`, width of `data_len`. Derived; not overridden.

- `clk` input 1: single clock, all logic on rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `deser_en` input 1: one-cycle strobe; `sampled_bit` is valid and is consumed this cycle.
- `sampled_bit` input 1: received data bit.
- `data_len` input LEN_W: frame length in bits, captured at frame start.
- `msb_first` input 1: 0 = first bit is LSB, 1 = first bit is MSB; captured at frame start.
- `par_odd` input 1: 0 = even parity, 1 = odd parity; captured at frame start.
- `clear` input 1: synchronous abort of the frame in progress.
- `p_data` output DATA_WIDTH: held frame data, right-aligned, upper bits zero.
- `p_parity` output 1: expected parity bit for the held frame.
- `p_valid` output 1: holding register contains an unconsumed frame.
- `p_ready` input 1: consumer accepts the frame when `p_valid && p_ready`.
- `busy` output 1: a frame is partially received (bit count ≠ 0).
- `overrun` output 1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Bit counter** `cnt` runs 0..len-1. **Frame start** is any `deser_en` while `cnt == 0`.
- At frame start, register the effective length `len`, `msb_first` and `par_odd`.
  - `data_len == 0` or `data_len > DATA_WIDTH`: `len = DATA_WIDTH`. Otherwise `len = data_len`.
  - Later changes to these inputs during a frame have no effect on that frame.
- **Assembly.** On each `deser_en`, bit k of the frame (k = 0 first) lands as follows:
  - LSB-first: into shift position k.
  - MSB-first: into position len-1-k (shift left, new bit into bit 0).
  - Either way, the final word is right-aligned, with bits ≥ len equal to zero.
  - The shift register is zeroed at frame start.
- **Parity.** A running XOR over the accepted bits. `p_parity` is that XOR for even parity, or its inverse for odd parity.
- **Completion.** The `deser_en` with `cnt == len-1` completes the frame; `cnt` returns to 0.
  - Completed word and parity load into `p_data`/`p_parity` and `p_valid` sets, provided the holding register is free: `!p_valid`, or `p_ready` asserted in the same cycle.
  - If the holding register is not free, the new frame is discarded, `p_data`/`p_parity` keep the old frame, and `overrun` pulses.
- **Handshake.** `p_valid` clears on `p_valid && p_ready` unless a completion loads in the same cycle; in that case it stays 1 with the new data.
  - `p_data`/`p_parity` are stable while `p_valid && !p_ready`.
- **Abort.** `clear` zeroes `cnt`, the shift register and the parity accumulator. It does not touch `p_data`, `p_parity` or `p_valid`.
  - `clear` and `deser_en` in the same cycle: `clear` wins and the bit is discarded.
- `deser_en` may assert on consecutive cycles; back-to-back frames need no gap.

## Timing
- Reset values: `p_data = 0`, `p_parity = 0`, `p_valid = 0`, `overrun = 0`, `busy = 0`, `cnt = 0`.
- Last-bit `deser_en` in cycle N:
  - `p_valid`/`p_data` update at the edge ending cycle N, visible in cycle N+1.
  - `overrun`, if any, is high in cycle N+1 only.
- `busy` is registered: high from the cycle after the first bit until the cycle after completion or `clear`.
- Minimum frame-to-frame spacing is 0 cycles. Throughput is one frame per `len` strobes, sustained with `p_ready` held high.
- `rst` asserted mid-frame: all state returns to reset values immediately. The frame is lost and no `overrun` is raised.

## Test plan
- DATA_WIDTH=8, `data_len=8`, LSB-first, even parity, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> `p_data=0x4D`, `p_parity=0`, `p_valid=1` one cycle after the last bit.
- `data_len=5`, MSB-first, odd parity, bits 1,0,1,1,1 -> `p_data=0x17`, upper 3 bits 0, `p_parity=1`; `busy` high for exactly 4 cycles.
- Frame 0xA5 completes with `p_ready=0`; a second frame 0x3C completes while still unread -> `p_data` stays 0xA5 and `overrun` pulses one cycle. Then `p_ready=1` -> `p_valid` drops.
- `p_ready=1` in the exact cycle a second frame completes -> `p_valid` stays 1 and `p_data` switches to the new word with no overrun.
- `clear` after 3 bits, then a full 8-bit frame 0xFF -> `p_data=0xFF`; none of the aborted bits leak into the result. Repeat with `clear` coincident with a `deser_en` and check that bit is dropped.
- `data_len=0` and `data_len=15` each produce 8-bit frames. `rst` pulse after 4 bits -> all outputs 0, and the next 8 bits form a clean frame.
